// File: rtl/example_acc_rnd_sat_if.sv
// Stream bundle between the multiplier array, the accumulator and the
// activation stage: product input, frame length and rounded result output.
interface example_acc_rnd_sat_if #(
    parameter int PROD_WIDTH = 21,
    parameter int OUT_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8
);
    logic        [LEN_WIDTH-1:0]  cfg_len;
    logic signed [PROD_WIDTH-1:0] prod_tdata;
    logic                         prod_tvalid;
    logic                         prod_tready;
    logic signed [OUT_WIDTH-1:0]  out_tdata;
    logic                         out_tvalid;
    logic                         out_tready;
    logic                         out_sat;

    modport master (
        output cfg_len, prod_tdata, prod_tvalid, out_tready,
        input  prod_tready, out_tdata, out_tvalid, out_sat
    );

    modport slave (
        input  cfg_len, prod_tdata, prod_tvalid, out_tready,
        output prod_tready, out_tdata, out_tvalid, out_sat
    );
endinterface

// File: rtl/example_acc_rnd_sat.sv
// Frame accumulator for signed products: sums cfg_len terms, rounds half
// toward +inf, drops SHIFT fraction bits and saturates to OUT_WIDTH.
module example_acc_rnd_sat #(
    parameter int PROD_WIDTH = 21,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 7,
    parameter int LEN_WIDTH  = 8
) (
    input logic ap_clk,
    input logic ap_rst,
    example_acc_rnd_sat_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;

    localparam logic signed [ACC_WIDTH:0] HALF =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] OMAX =
        (ACC_WIDTH + 1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] OMIN = ~OMAX;

    state_t state;
    state_t state_nx;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic        [LEN_WIDTH-1:0] len_q;
    logic        [LEN_WIDTH-1:0] len_in;
    logic        [LEN_WIDTH-1:0] count;
    logic signed [ACC_WIDTH:0]   rnd;
    logic signed [ACC_WIDTH:0]   r;
    logic                        beat;

    assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){bus.prod_tdata[PROD_WIDTH-1]}},
                       bus.prod_tdata};
    assign len_in   = (bus.cfg_len == '0) ? LEN_WIDTH'(1) : bus.cfg_len;
    assign beat     = bus.prod_tvalid && bus.prod_tready;

    // One extra bit keeps the rounding add from overflowing.
    assign rnd = {acc[ACC_WIDTH-1], acc} + HALF;
    assign r   = rnd >>> SHIFT;

    assign bus.prod_tready = !ap_rst && (state == IDLE || state == ACC);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (beat) state_nx = (len_in == LEN_WIDTH'(1)) ? ROUND : ACC;
            end
            ACC: begin
                if (beat && (count + 1'b1) == len_q) state_nx = ROUND;
            end
            ROUND: state_nx = OUT;
            OUT: begin
                if (bus.out_tready) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state          <= IDLE;
            acc            <= '0;
            count          <= '0;
            len_q          <= '0;
            bus.out_tdata  <= '0;
            bus.out_tvalid <= 1'b0;
            bus.out_sat    <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (beat) begin
                        acc   <= prod_ext;
                        len_q <= len_in;
                        count <= LEN_WIDTH'(1);
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc   <= acc + prod_ext;
                        count <= count + 1'b1;
                    end
                end
                ROUND: begin
                    bus.out_tvalid <= 1'b1;
                    if (r > OMAX) begin
                        bus.out_tdata <= OMAX[OUT_WIDTH-1:0];
                        bus.out_sat   <= 1'b1;
                    end else if (r < OMIN) begin
                        bus.out_tdata <= OMIN[OUT_WIDTH-1:0];
                        bus.out_sat   <= 1'b1;
                    end else begin
                        bus.out_tdata <= r[OUT_WIDTH-1:0];
                        bus.out_sat   <= 1'b0;
                    end
                end
                OUT: begin
                    if (bus.out_tready) bus.out_tvalid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/example_acc_rnd_sat.md
Name: example_acc_rnd_sat

Overview:
- Downstream consumer of the 7x14 signed multiplier stage.
- Accepts a stream of 21-bit signed products and accumulates a configurable number of terms into a wide accumulator.
- Rounds and right-shifts the sum, saturates it to the output width, and presents one result per frame on a valid/ready output.
- Sits between the multiplier array and the activation/next-layer stages of the GNN datapath.

Parameters:
PROD_WIDTH, 21, signed product input width
ACC_WIDTH, 32, signed accumulator width (must be > PROD_WIDTH + LEN_WIDTH)
OUT_WIDTH, 16, signed result width
SHIFT, 7, fractional bits dropped at output (>= 1)
LEN_WIDTH, 8, width of the term-count field

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst  in  1  synchronous reset, active-high
cfg_len  in  LEN_WIDTH  terms per frame; sampled on first accepted beat of a frame
prod_tdata  in  PROD_WIDTH  signed product
prod_tvalid  in  1  product valid
prod_tready  out  1  block can accept a product
out_tdata  out  OUT_WIDTH  signed rounded/saturated result
out_tvalid  out  1  result valid
out_tready  in  1  downstream accepts result
out_sat  out  1  result was clipped; qualified by out_tvalid

Behaviour:
- One clock ap_clk; reset ap_rst is synchronous and active-high.
- Reset values: state=IDLE, acc=0, count=0, prod_tready=0 during the reset cycle then 1, out_tvalid=0, out_tdata=0, out_sat=0.
- A beat transfers when prod_tvalid && prod_tready. A result transfers when out_tvalid && out_tready.
- States:
  - IDLE: prod_tready=1.
    - On a transfer: acc <= sext(prod_tdata); len_q <= (cfg_len==0 ? 1 : cfg_len); count <= 1.
    - If len_q would be 1, go to ROUND; else go to ACC.
  - ACC: prod_tready=1.
    - On each transfer: acc <= acc + sext(prod_tdata); count <= count+1.
    - The transfer that makes count==len_q goes to ROUND.
    - No transfer: hold.
  - ROUND: prod_tready=0.
    - r = (acc + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, so round half toward +inf.
    - r > 2^(OUT_WIDTH-1)-1: out_tdata=max, out_sat=1.
    - r < -2^(OUT_WIDTH-1): out_tdata=min, out_sat=1.
    - Otherwise out_tdata=r[OUT_WIDTH-1:0], out_sat=0.
    - Outputs are registered; out_tvalid <= 1; go to OUT.
  - OUT: prod_tready=0.
    - out_tdata, out_sat and out_tvalid are held stable until out_tready.
    - On transfer: out_tvalid <= 0; go to IDLE. prod_tready returns to 1 the following cycle. No same-cycle bypass.
- Arithmetic:
  - Products are sign-extended to ACC_WIDTH.
  - The accumulator wraps modulo 2^ACC_WIDTH. Parameter choice guarantees it cannot overflow for len <= 2^LEN_WIDTH.
  - The rounding add is performed at ACC_WIDTH+1 bits, so it never overflows.
- Latency:
  - The last beat is accepted in cycle t. out_tvalid is high in cycle t+2.
  - Minimum frame period is len+2 cycles with out_tready tied high.
- cfg_len:
  - Changes to cfg_len mid-frame are ignored.
  - cfg_len=0 is treated as 1.
- Reset mid-frame: the partial sum is discarded and all state returns to its reset values. A pending output is dropped.
- prod_tvalid is ignored while prod_tready=0. Upstream must hold the beat.

Test Plan:
1. Basic sum and latency: len=4, products 100,200,-50,378 back-to-back, out_tready=1.
   - Required: out_tdata=5, out_sat=0.
   - Required: out_tvalid exactly 2 cycles after the 4th beat, high for 1 cycle.
2. Negative rounding, two frames:
   - len=1, prod=-192 -> out_tdata=-1 (0xFFFF).
   - len=1, prod=-193 -> out_tdata=-2.
   - len=1, prod=64 -> out_tdata=1.
3. Saturation boundaries:
   - len=4, four beats of 1048575 -> out_tdata=32767, out_sat=1.
   - len=4, four beats of -1048576 -> out_tdata=-32768, out_sat=0 (exact minimum).
4. Backpressure:
   - Setup: frame len=2 (products 256,256). Hold out_tready=0 for 5 cycles while prod_tvalid=1 with new data.
   - Required: out_tdata=4, stable, out_tvalid=1 throughout; prod_tready=0; no beat consumed.
   - After out_tready=1 for one cycle: out_tvalid drops, and prod_tready=1 on the next cycle.
5. cfg_len=0 with prod=640 -> treated as one term: out_tdata=5, produced 2 cycles after the single beat.
6. Reset mid-frame:
   - Stimulus: len=4; after 2 beats (1000,1000) assert ap_rst for 1 cycle.
   - Required: out_tvalid=0, out_tdata=0.
   - Then a new frame len=1, prod=128 -> out_tdata=1, with no residue of the prior partial sum.
